// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - Job sequencer for the weight-stationary systolic array (load, switch, skewed stream, drain).
// Optional performance counters are enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int MAX_ROWS             = 256,
  parameter int DRAIN_TIMEOUT        = 64,
  localparam int ROW_W               = $clog2(MAX_ROWS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ROW_W-1:0] cmd_num_rows,
  input  logic [15:0]      cmd_col_size,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [15:0]      w_data_1,
  input  logic [15:0]      w_data_2,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [15:0]      x_data_1,
  input  logic [15:0]      x_data_2,
  output logic [15:0]      sys_data_in_1x,
  output logic [15:0]      sys_data_in_2x,
  output logic             sys_start,
  output logic [15:0]      sys_weight_in_x1,
  output logic [15:0]      sys_weight_in_x2,
  output logic             sys_accept_w_1,
  output logic             sys_accept_w_2,
  output logic             sys_switch_in,
  output logic [15:0]      ub_rd_col_size_in,
  output logic             ub_rd_col_size_valid_in,
  input  logic             sys_valid_out_x1,
  input  logic             sys_valid_out_x2,
  output logic             busy,
  output logic             done,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic             err,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall,
  output logic             perf_valid
`else
  output logic             err
`endif
);

  localparam int WC_W = $clog2(SYSTOLIC_ARRAY_WIDTH + 1);
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [15:0]     WIDTH16 = 16'(SYSTOLIC_ARRAY_WIDTH);
  localparam logic [WC_W-1:0] LAST_W  = WC_W'(SYSTOLIC_ARRAY_WIDTH - 1);
  localparam logic [TO_W-1:0] LAST_TO = TO_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM, FLUSH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ROW_W-1:0] num_rows_q, rows_sent, results_seen;
  logic [15:0]      col_q, skew_q;
  logic [WC_W-1:0]  w_cnt;
  logic [TO_W-1:0]  idle_cnt;
  logic             cmd_fire, w_fire, x_fire, res_pulse, res_inc, done_set, err_set;

  assign busy    = (state != IDLE);
  assign w_ready = (state == LOAD_W);
  assign x_ready = (state == STREAM) && (rows_sent != num_rows_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_fire  = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    w_fire    = w_ready && w_valid;
    x_fire    = x_ready && x_valid;
    res_pulse = (col_q == 16'd2) ? sys_valid_out_x2 : sys_valid_out_x1;
    // Results can overtake the drain phase, so counting starts with streaming.
    res_inc   = res_pulse && (state == STREAM || state == FLUSH || state == DRAIN) &&
                (results_seen != num_rows_q);
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_num_rows == '0 || cmd_col_size == 16'd0 || cmd_col_size > WIDTH16) begin
            err_set = 1'b1;
          end else begin
            cmd_fire  = 1'b1;
            state_nxt = LOAD_W;
          end
        end
      end
      LOAD_W: if (w_fire && w_cnt == LAST_W) state_nxt = SWITCH;
      SWITCH: state_nxt = STREAM;
      STREAM: if (x_fire && rows_sent == num_rows_q - ROW_W'(1)) state_nxt = FLUSH;
      FLUSH:  state_nxt = DRAIN;
      DRAIN: begin
        if (results_seen + ROW_W'(res_inc) == num_rows_q) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end else if (!res_inc && idle_cnt == LAST_TO) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready               <= 1'b0;
      done                    <= 1'b0;
      err                     <= 1'b0;
      ub_rd_col_size_in       <= '0;
      ub_rd_col_size_valid_in <= 1'b0;
      num_rows_q              <= '0;
      col_q                   <= '0;
      w_cnt                   <= '0;
      rows_sent               <= '0;
      results_seen            <= '0;
      idle_cnt                <= '0;
      sys_weight_in_x1        <= '0;
      sys_weight_in_x2        <= '0;
      sys_accept_w_1          <= 1'b0;
      sys_accept_w_2          <= 1'b0;
      sys_switch_in           <= 1'b0;
      sys_start               <= 1'b0;
      sys_data_in_1x          <= '0;
      sys_data_in_2x          <= '0;
      skew_q                  <= '0;
    end else begin
      cmd_ready               <= (state_nxt == IDLE);
      done                    <= done_set;
      err                     <= err_set;
      ub_rd_col_size_valid_in <= cmd_fire;
      if (cmd_fire) begin
        num_rows_q        <= cmd_num_rows;
        col_q             <= cmd_col_size;
        ub_rd_col_size_in <= cmd_col_size;
        w_cnt             <= '0;
        rows_sent         <= '0;
        results_seen      <= '0;
      end
      sys_accept_w_1 <= w_fire;
      sys_accept_w_2 <= w_fire;
      if (w_fire) begin
        sys_weight_in_x1 <= w_data_1;
        sys_weight_in_x2 <= w_data_2;
        w_cnt            <= w_cnt + WC_W'(1);
      end
      sys_switch_in <= (state == SWITCH);
      // Row 2 rides one extra register so the array sees a diagonal wavefront.
      sys_start      <= x_fire;
      sys_data_in_1x <= x_fire ? x_data_1 : 16'd0;
      skew_q         <= x_fire ? x_data_2 : 16'd0;
      sys_data_in_2x <= skew_q;
      if (x_fire)  rows_sent    <= rows_sent + ROW_W'(1);
      if (res_inc) results_seen <= results_seen + ROW_W'(1);
      if (state != DRAIN || res_inc) idle_cnt <= '0;
      else                           idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
      perf_valid  <= 1'b0;
    end else begin
      perf_valid <= done_set;
      if (cmd_fire) begin
        perf_cycles <= 32'd1;
        perf_stall  <= '0;
      end else begin
        if (state != IDLE)        perf_cycles <= perf_cycles + 32'd1;
        if (x_ready && !x_valid)  perf_stall  <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - Directed self-checking bench for systolic_ctrl.
module tb_systolic_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_num_rows = '0;
  logic [15:0] cmd_col_size = '0;
  logic        w_valid = 1'b0, w_ready;
  logic [15:0] w_data_1 = '0, w_data_2 = '0;
  logic        x_valid = 1'b0, x_ready;
  logic [15:0] x_data_1 = '0, x_data_2 = '0;
  logic [15:0] sys_data_in_1x, sys_data_in_2x;
  logic        sys_start;
  logic [15:0] sys_weight_in_x1, sys_weight_in_x2;
  logic        sys_accept_w_1, sys_accept_w_2, sys_switch_in;
  logic [15:0] ub_rd_col_size_in;
  logic        ub_rd_col_size_valid_in;
  logic        sys_valid_out_x1 = 1'b0, sys_valid_out_x2 = 1'b0;
  logic        busy, done, err;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
  logic        perf_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num_rows(cmd_num_rows), .cmd_col_size(cmd_col_size),
    .w_valid(w_valid), .w_ready(w_ready), .w_data_1(w_data_1), .w_data_2(w_data_2),
    .x_valid(x_valid), .x_ready(x_ready), .x_data_1(x_data_1), .x_data_2(x_data_2),
    .sys_data_in_1x(sys_data_in_1x), .sys_data_in_2x(sys_data_in_2x), .sys_start(sys_start),
    .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in),
    .ub_rd_col_size_in(ub_rd_col_size_in), .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .sys_valid_out_x1(sys_valid_out_x1), .sys_valid_out_x2(sys_valid_out_x2),
    .busy(busy), .done(done),
`ifdef SYSTOLIC_CTRL_PERF_EN
    .err(err), .perf_cycles(perf_cycles), .perf_stall(perf_stall), .perf_valid(perf_valid)
`else
    .err(err)
`endif
  );

  // Concatenation of every DUT output; all must be zero under reset.
  function automatic logic [153:0] all_outs();
    return {cmd_ready, w_ready, x_ready, sys_data_in_1x, sys_data_in_2x, sys_start,
            sys_weight_in_x1, sys_weight_in_x2, sys_accept_w_1, sys_accept_w_2, sys_switch_in,
            ub_rd_col_size_in, ub_rd_col_size_valid_in, busy, done, err, 58'd0};
  endfunction

  // Issues a good command, feeds two weight beats and returns at the negedge where STREAM begins.
  task automatic start_job(input logic [8:0] rows, input logic [15:0] col);
    cmd_valid = 1'b1; cmd_num_rows = rows; cmd_col_size = col;
    @(negedge clk); cmd_valid = 1'b0; w_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); w_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_outs()); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_bad_cmd();
    logic [8:0]  rows [2] = '{9'd0, 9'd3};
    logic [15:0] cols [2] = '{16'd2, 16'd3};
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_num_rows = rows[i]; cmd_col_size = cols[i];
      @(negedge clk); cmd_valid = 1'b0;
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bad_cmd_err%0d: got err=%b busy=%b required err=1 busy=0", i, err, busy); end
      checks++; if ({sys_accept_w_1, sys_switch_in, sys_start, ub_rd_col_size_valid_in} !== 4'b0) begin
        errors++; $display("FAIL bad_cmd_quiet%0d: got %b required 0000", i, {sys_accept_w_1, sys_switch_in, sys_start, ub_rd_col_size_valid_in}); end
      @(negedge clk);
      checks++; if (err !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bad_cmd_pulse%0d: got err=%b ready=%b required err=0 ready=1", i, err, cmd_ready); end
    end
  endtask

  task automatic test_weights();
    cmd_valid = 1'b1; cmd_num_rows = 9'd3; cmd_col_size = 16'd2;
    @(negedge clk); cmd_valid = 1'b0;
    checks++; if (ub_rd_col_size_valid_in !== 1'b1 || ub_rd_col_size_in !== 16'd2) begin
      errors++; $display("FAIL ub_strobe: got v=%b col=%0d required v=1 col=2", ub_rd_col_size_valid_in, ub_rd_col_size_in); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || w_ready !== 1'b1) begin
      errors++; $display("FAIL load_entry: got busy=%b ready=%b w_ready=%b required 1 0 1", busy, cmd_ready, w_ready); end
    w_valid = 1'b1; w_data_1 = 16'd5; w_data_2 = 16'd6;
    @(negedge clk);
    checks++; if ({sys_accept_w_1, sys_accept_w_2, sys_weight_in_x1, sys_weight_in_x2, sys_switch_in} !== {2'b11, 16'd5, 16'd6, 1'b0}) begin
      errors++; $display("FAIL weight_beat1: got acc=%b%b w=%0d,%0d sw=%b required 11 5,6 0", sys_accept_w_1, sys_accept_w_2, sys_weight_in_x1, sys_weight_in_x2, sys_switch_in); end
    w_data_1 = 16'd7; w_data_2 = 16'd8;
    @(negedge clk); w_valid = 1'b0;
    checks++; if ({sys_accept_w_1, sys_accept_w_2, sys_weight_in_x1, sys_weight_in_x2, sys_switch_in} !== {2'b11, 16'd7, 16'd8, 1'b0}) begin
      errors++; $display("FAIL weight_beat2: got acc=%b%b w=%0d,%0d sw=%b required 11 7,8 0", sys_accept_w_1, sys_accept_w_2, sys_weight_in_x1, sys_weight_in_x2, sys_switch_in); end
    @(negedge clk);
    checks++; if ({sys_switch_in, sys_accept_w_1, sys_accept_w_2, sys_weight_in_x1, sys_weight_in_x2} !== {3'b100, 16'd7, 16'd8}) begin
      errors++; $display("FAIL switch_pulse: got sw=%b acc=%b%b w=%0d,%0d required 1 00 7,8", sys_switch_in, sys_accept_w_1, sys_accept_w_2, sys_weight_in_x1, sys_weight_in_x2); end
    checks++; if (x_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b required 1", x_ready); end
  endtask

  task automatic test_stream();
    int done_cnt = 0, done_at = -1;
    logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    x_valid = 1'b1; x_data_1 = 16'd1; x_data_2 = 16'd2;
    @(negedge clk);
    checks++; if ({sys_start, sys_data_in_1x, sys_data_in_2x, sys_switch_in} !== {1'b1, 16'd1, 16'd0, 1'b0}) begin
      errors++; $display("FAIL stream_row1: got st=%b d1=%0d d2=%0d sw=%b required 1 1 0 0", sys_start, sys_data_in_1x, sys_data_in_2x, sys_switch_in); end
    x_data_1 = 16'd3; x_data_2 = 16'd4;
    @(negedge clk);
    checks++; if ({sys_start, sys_data_in_1x, sys_data_in_2x} !== {1'b1, 16'd3, 16'd2}) begin
      errors++; $display("FAIL stream_row2: got st=%b d1=%0d d2=%0d required 1 3 2", sys_start, sys_data_in_1x, sys_data_in_2x); end
    x_data_1 = 16'd9; x_data_2 = 16'd10;
    @(negedge clk); x_valid = 1'b0;
    checks++; if ({sys_start, sys_data_in_1x, sys_data_in_2x, x_ready} !== {1'b1, 16'd9, 16'd4, 1'b0}) begin
      errors++; $display("FAIL stream_row3: got st=%b d1=%0d d2=%0d rdy=%b required 1 9 4 0", sys_start, sys_data_in_1x, sys_data_in_2x, x_ready); end
    @(negedge clk);
    checks++; if ({sys_start, sys_data_in_1x, sys_data_in_2x} !== {1'b0, 16'd0, 16'd10}) begin
      errors++; $display("FAIL stream_flush: got st=%b d1=%0d d2=%0d required 0 0 10", sys_start, sys_data_in_1x, sys_data_in_2x); end
    for (int k = 0; k < 8; k++) begin
      sys_valid_out_x2 = pat[k];
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
    end
    sys_valid_out_x2 = 1'b0;
    checks++; if (done_cnt != 1 || done_at != 4) begin errors++; $display("FAIL stream_done: got count=%0d at=%0d required count=1 at=4", done_cnt, done_at); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL stream_idle: got busy=%b ready=%b required 0 1", busy, cmd_ready); end
  endtask

  task automatic test_bubbles();
    logic [6:0] st_bits = '0, r2_bits = '0;
    logic [15:0] d1 [7], d2 [7];
    logic        pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] xa [5] = '{16'd11, 16'd0, 16'd13, 16'd0, 16'd15};
    logic [15:0] xb [5] = '{16'd21, 16'd0, 16'd23, 16'd0, 16'd25};
    int done_cnt = 0, done_at = -1;
    start_job(9'd3, 16'd2);
    for (int k = 0; k < 13; k++) begin
      x_valid  = (k < 5) ? pat[k] : 1'b0;
      x_data_1 = (k < 5) ? xa[k] : 16'd0;
      x_data_2 = (k < 5) ? xb[k] : 16'd0;
      sys_valid_out_x2 = (k == 4 || k == 7 || k == 8);
      @(negedge clk);
      if (k < 7) begin
        st_bits[k] = sys_start; r2_bits[k] = (sys_data_in_2x != 16'd0);
        d1[k] = sys_data_in_1x; d2[k] = sys_data_in_2x;
      end
      if (done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
    end
    sys_valid_out_x2 = 1'b0;
    checks++; if (st_bits !== 7'b0010101) begin errors++; $display("FAIL bubble_start: got %b required 0010101", st_bits); end
    checks++; if (r2_bits !== 7'b0101010) begin errors++; $display("FAIL bubble_row2: got %b required 0101010", r2_bits); end
    checks++; if ({d1[0], d1[2], d1[4], d2[1], d2[3], d2[5]} !== {16'd11, 16'd13, 16'd15, 16'd21, 16'd23, 16'd25}) begin
      errors++; $display("FAIL bubble_data: got %0d %0d %0d / %0d %0d %0d required 11 13 15 / 21 23 25", d1[0], d1[2], d1[4], d2[1], d2[3], d2[5]); end
    checks++; if (done_cnt != 1 || done_at != 8) begin errors++; $display("FAIL bubble_done: got count=%0d at=%0d required count=1 at=8", done_cnt, done_at); end
  endtask

  task automatic test_col1();
    int done_cnt = 0, done_at = -1;
    start_job(9'd2, 16'd1);
    checks++; if (ub_rd_col_size_in !== 16'd1) begin errors++; $display("FAIL col1_ub: got %0d required 1", ub_rd_col_size_in); end
    for (int k = 0; k < 12; k++) begin
      x_valid = (k < 2); x_data_1 = 16'd61 + 16'(k); x_data_2 = 16'd62 + 16'(k);
      sys_valid_out_x2 = 1'b1;
      sys_valid_out_x1 = (k == 4 || k == 5);
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
    end
    sys_valid_out_x1 = 1'b0; sys_valid_out_x2 = 1'b0; x_valid = 1'b0;
    checks++; if (done_cnt != 1 || done_at != 5) begin errors++; $display("FAIL col1_done: got count=%0d at=%0d required count=1 at=5", done_cnt, done_at); end
  endtask

  task automatic test_timeout();
    int err_cnt = 0, err_at = -1, last2x = -1, done_cnt = 0;
    start_job(9'd2, 16'd2);
    for (int k = 0; k < 80; k++) begin
      x_valid = (k < 2); x_data_1 = 16'd31 + 16'(2 * k); x_data_2 = 16'd32 + 16'(2 * k);
      @(negedge clk);
      if (sys_data_in_2x != 16'd0) last2x = k;
      if (err === 1'b1) begin err_cnt++; if (err_at < 0) err_at = k; end
      if (done === 1'b1) done_cnt++;
    end
    x_valid = 1'b0;
    checks++; if (last2x != 2 || err_at - last2x != 64) begin errors++; $display("FAIL timeout_delay: got flush_at=%0d err_at=%0d required 2 and 66", last2x, err_at); end
    checks++; if (err_cnt != 1 || done_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got errs=%0d dones=%0d busy=%b required 1 0 0", err_cnt, done_cnt, busy); end
  endtask

  task automatic test_reset_mid();
    int flag_cnt = 0;
    start_job(9'd3, 16'd2);
    x_valid = 1'b1; x_data_1 = 16'd41; x_data_2 = 16'd42;
    @(negedge clk);
    checks++; if (sys_start !== 1'b1 || sys_data_in_1x !== 16'd41) begin errors++; $display("FAIL rst_mid_pre: got st=%b d1=%0d required 1 41", sys_start, sys_data_in_1x); end
    x_data_1 = 16'd43; x_data_2 = 16'd44;
    #2 rst_n = 1'b0; x_valid = 1'b0;
    #1;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h required 0", all_outs()); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) flag_cnt++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || flag_cnt != 0) begin
      errors++; $display("FAIL rst_mid_idle: got ready=%b busy=%b flags=%0d required 1 0 0", cmd_ready, busy, flag_cnt); end
    start_job(9'd1, 16'd2);
    x_valid = 1'b1; x_data_1 = 16'd51; x_data_2 = 16'd52;
    @(negedge clk); x_valid = 1'b0;
    checks++; if (sys_start !== 1'b1 || sys_data_in_1x !== 16'd51) begin errors++; $display("FAIL rst_next_row: got st=%b d1=%0d required 1 51", sys_start, sys_data_in_1x); end
    @(negedge clk);
    checks++; if (sys_data_in_2x !== 16'd52) begin errors++; $display("FAIL rst_next_skew: got %0d required 52", sys_data_in_2x); end
    sys_valid_out_x2 = 1'b1;
    @(negedge clk); sys_valid_out_x2 = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rst_next_done: got done=%b err=%b required 1 0", done, err); end
  endtask

  initial begin
    test_reset();
    test_bad_cmd();
    test_weights();
    test_stream();
    test_bubbles();
    test_col1();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
